load_align_unit: RTL and testbench
==================================

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before abort (1..255).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  load request present.
REQ-006 SHALL have port req_ready  out  1  unit can accept a request.
REQ-007 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-008 SHALL have port req_op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 reserved, 101 LW, 110 LWL, 111 LWR.
REQ-009 SHALL have port req_rt_old  in  32  previous rt value, merged by LWL/LWR.
REQ-010 SHALL have port mem_rd_en  out  1  one-cycle memory read strobe.
REQ-011 SHALL have port mem_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
REQ-012 SHALL have port mem_rdata  in  32  read word, little-endian byte lanes.
REQ-013 SHALL have port mem_rvalid  in  1  mem_rdata valid this cycle.
REQ-014 SHALL have port resp_valid  out  1  result present.
REQ-015 SHALL have port resp_ready  in  1  consumer takes result.
REQ-016 SHALL have port resp_data  out  32  formatted load result.
REQ-017 SHALL have port resp_err  out  2  00 ok, 01 address error, 10 timeout, 11 illegal op.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE; request, addr, op, rt_old captured on req_valid&&req_ready.
REQ-019 SHALL go IDLE->ISSUE on accepted legal request; ISSUE asserts mem_rd_en for exactly one cycle, then WAIT.
REQ-020 SHALL honour mem_rvalid only in WAIT; ignore it in IDLE, ISSUE, RESP.
REQ-021 SHALL go WAIT->RESP on mem_rvalid, registering the formatted data; minimum latency accept-to-resp_valid is 3 cycles.
REQ-022 SHALL count WAIT cycles (8-bit counter, cleared on entering WAIT); after TIMEOUT cycles without mem_rvalid go to RESP, resp_err=10, resp_data=0.
REQ-023 SHALL go IDLE->RESP directly (next cycle, no mem_rd_en) for op 100 (err 11) or address error (err 01), resp_data=0.
REQ-024 SHALL hold resp_valid, resp_data, resp_err stable in RESP until resp_ready; RESP->IDLE on resp_ready; no new request in the same cycle.
REQ-025 SHALL format, with k=addr[1:0]: LB/LBU byte lane k sign-/zero-extended; LH/LHU half lane addr[1] sign-/zero-extended; LW full word.
REQ-026 SHALL form LWL = (word << 8*(3-k)) | (rt_old & low 8*(3-k) bits); LWR = (word >> 8*k) | (rt_old & top 8*k bits).
REQ-027 SHALL sign-extend by replicating the lane MSB across all upper bits.

Reset
REQ-028 SHALL, while rst_n=0: state IDLE, req_ready=0, mem_rd_en=0, mem_addr=0, resp_valid=0, resp_data=0, resp_err=00, counter 0.
REQ-029 SHALL set req_ready=1 on the first clk edge after rst_n rises; reset in any state aborts the operation with no response.

Configuration
REQ-030 SHALL, with LOAD_ALIGN_MISALIGN_EN defined, flag err 01 for LH/LHU with addr[0]=1 and LW with addr[1:0]!=0.
REQ-031 SHALL, without LOAD_ALIGN_MISALIGN_EN, never produce err 01; LH/LHU ignore addr[0]; LW ignores addr[1:0].

Structure
REQ-032 SHALL take op enum, resp_err enum, FSM state enum and field widths from package load_align_pkg.
REQ-033 SHALL place lane select, extension and LWL/LWR merge in combinational sub-module load_align_fmt.

Verification
REQ-034 SHALL cover LB addr 0x1003, mem_rdata 0x80AABB11 -> resp_data 0xFFFFFF80, err 00, resp_valid 3 cycles after accept.
REQ-035 SHALL cover LHU addr 0x2002, mem_rdata 0x80011234 -> 0x00008001; LH same -> 0xFFFF8001.
REQ-036 SHALL cover LWL addr 0x3001, word 0x44332211, rt_old 0xAABBCCDD -> 0x2211CCDD; LWR addr 0x3002 same -> 0xAABB4433.
REQ-037 SHALL cover no mem_rvalid, TIMEOUT=15 -> resp_err 10, data 0 after 15 WAIT cycles; late mem_rvalid in RESP ignored.
REQ-038 SHALL cover LW addr 0x1002 with macro -> err 01, mem_rd_en never high, resp_valid next cycle; without macro -> normal LW.
REQ-039 SHALL cover resp_ready low 3 cycles -> outputs stable; rst_n low in WAIT -> IDLE, all outputs 0, no response.

Source files
------------

// File: rtl/load_align_pkg.sv
// Shared types for the load alignment unit: op/err/state encodings and field widths.
package load_align_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;
  localparam int ERR_W  = 2;
  localparam int CNT_W  = 8;

  typedef enum logic [OP_W-1:0] {
    OP_LB   = 3'b000,
    OP_LBU  = 3'b001,
    OP_LH   = 3'b010,
    OP_LHU  = 3'b011,
    OP_RSVD = 3'b100,
    OP_LW   = 3'b101,
    OP_LWL  = 3'b110,
    OP_LWR  = 3'b111
  } op_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_OK      = 2'b00,
    ERR_ADDR    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ILLEGAL = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Halfword loads need addr[0]==0, full-word loads need addr[1:0]==0.
  function automatic logic is_misaligned(input op_e op, input logic [1:0] lsb);
    return ((op == OP_LH || op == OP_LHU) && lsb[0]) ||
           ((op == OP_LW) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/load_align_fmt.sv
// Combinational load formatter: byte/half lane select, sign/zero extension, LWL/LWR merge.
module load_align_fmt
  import load_align_pkg::*;
(
  input  op_e                i_op,
  input  logic [1:0]         i_lsb,
  input  logic [DATA_W-1:0]  i_word,
  input  logic [DATA_W-1:0]  i_rt_old,
  output logic [DATA_W-1:0]  o_data
);

  logic [4:0]  w_sh_r;
  logic [4:0]  w_sh_l;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_sh_r = {i_lsb, 3'b000};
  // ~k equals 3-k for a 2-bit k, so this is 8*(3-k).
  assign w_sh_l = {~i_lsb, 3'b000};
  assign w_byte = 8'(i_word >> w_sh_r);
  assign w_half = i_lsb[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    // NOTE: default first so no path through the case leaves o_data unassigned (no latch).
    o_data = '0;
    case (i_op)
      OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_data = {24'h0, w_byte};
      OP_LH:   o_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_data = {16'h0, w_half};
      OP_LW:   o_data = i_word;
      OP_LWL:  o_data = (i_word << w_sh_l) | (i_rt_old & ~(32'hFFFF_FFFF << w_sh_l));
      OP_LWR:  o_data = (i_word >> w_sh_r) | (i_rt_old & ~(32'hFFFF_FFFF >> w_sh_r));
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment unit: one outstanding word read, formatted per load op, with timeout.
// Define LOAD_ALIGN_MISALIGN_EN to reject misaligned LH/LHU/LW with an address error.
module load_align_unit
  import load_align_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [OP_W-1:0]      req_op,
  input  logic [DATA_W-1:0]    req_rt_old,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_rvalid,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    resp_data,
  output logic [ERR_W-1:0]     resp_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_rst_done;
  logic [ADDR_W-1:0]   r_addr;
  op_e                 r_op;
  logic [DATA_W-1:0]   r_rt_old;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [DATA_W-1:0]   r_resp_data;
  err_e                r_resp_err;

  op_e                 w_op;
  logic                w_accept;
  logic                w_illegal;
  logic                w_addr_err;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_fmt_data;

  assign w_op      = op_e'(req_op);
  assign w_accept  = req_valid && req_ready;
  assign w_illegal = (w_op == OP_RSVD);
  assign w_timeout = (r_wait_cnt == CNT_LAST);

`ifdef LOAD_ALIGN_MISALIGN_EN
  assign w_addr_err = is_misaligned(w_op, req_addr[1:0]);
`else
  assign w_addr_err = 1'b0;
`endif

  // Ready is held low until the first edge after reset release.
  assign req_ready  = (r_state == ST_IDLE) && r_rst_done;
  assign mem_rd_en  = (r_state == ST_ISSUE);
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign resp_valid = (r_state == ST_RESP);
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

  load_align_fmt u_fmt (
    .i_op     (r_op),
    .i_lsb    (r_addr[1:0]),
    .i_word   (mem_rdata),
    .i_rt_old (r_rt_old),
    .o_data   (w_fmt_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = (w_illegal || w_addr_err) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (mem_rvalid || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  if (resp_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done  <= 1'b0;
      r_addr      <= '0;
      r_op        <= OP_LB;
      r_rt_old    <= '0;
      r_wait_cnt  <= '0;
      r_resp_data <= '0;
      r_resp_err  <= ERR_OK;
    end else begin
      r_rst_done <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr      <= req_addr;
            r_op        <= w_op;
            r_rt_old    <= req_rt_old;
            r_resp_data <= '0;
            if (w_illegal)       r_resp_err <= ERR_ILLEGAL;
            else if (w_addr_err) r_resp_err <= ERR_ADDR;
            else                 r_resp_err <= ERR_OK;
          end
        end
        ST_ISSUE: r_wait_cnt <= '0;
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_resp_data <= w_fmt_data;
            r_resp_err  <= ERR_OK;
          end else if (w_timeout) begin
            r_resp_data <= '0;
            r_resp_err  <= ERR_TIMEOUT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit; expectations are hand-computed constants.
module tb_load_align_unit;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_rt_old = '0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_align_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_op     (req_op),
    .req_rt_old (req_rt_old),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one load, plays a memory that answers rv_delay cycles into WAIT (negative: never),
  // and observes the response. lat counts cycles from the accept cycle (accept cycle = 0).
  task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] rt_old, input logic [31:0] rdata, input int rv_delay,
                         input logic [31:0] exp_data, input logic [1:0] exp_err,
                         input int exp_lat, input int exp_rd, input int hold, input bit late_rv);
    int wait_n, lat, rd_cnt, rd_at;
    logic got;
    logic [31:0] maddr;
    @(negedge clk);
    wait_n = 0;
    while (!req_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_rt_old = rt_old;
    @(negedge clk);
    req_valid = 1'b0; req_op = ~op; req_addr = ~addr; req_rt_old = ~rt_old;
    lat = 1; rd_cnt = 0; rd_at = -100; got = 1'b0; maddr = '0;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
      if (mem_rd_en) begin
        rd_cnt++;
        rd_at = lat;
        maddr = mem_addr;
      end
      mem_rvalid = (rv_delay >= 0) && (rd_cnt > 0) && (lat == rd_at + 1 + rv_delay);
      mem_rdata  = mem_rvalid ? rdata : 32'hDEAD_BEEF;
      @(negedge clk);
      lat++;
    end
    mem_rvalid = 1'b0;
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    check({tag, "_data"}, resp_data, exp_data);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rd_en_cycles"}, 32'(rd_cnt), 32'(exp_rd));
    if (exp_rd > 0) check({tag, "_mem_addr"}, maddr, addr & 32'hFFFF_FFFC);
    if (late_rv) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      mem_rvalid = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_data"}, resp_data, exp_data);
      check({tag, "_hold_err"}, 32'(resp_err), 32'(exp_err));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_released"}, 32'(resp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_data"}, resp_data, 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1;
    check("rst_release_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rst_release_ready", 32'(req_ready), 32'd1);

    // Stray mem_rvalid while idle must not produce a response.
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("idle_rvalid_no_resp", 32'(resp_valid), 32'd0);

    //       tag         op      addr          rt_old        rdata         rv  exp_data      err    lat rd hold late
    do_load("lb_k3",    3'b000, 32'h0000_1003, 32'h0,        32'h80AA_BB11, 0, 32'hFFFF_FF80, 2'b00, 3, 1, 0, 0);
    do_load("lb_k0",    3'b000, 32'h0000_1000, 32'h0,        32'h80AA_BB11, 0, 32'h0000_0011, 2'b00, 3, 1, 0, 0);
    do_load("lb_k2",    3'b000, 32'h0000_1002, 32'h0,        32'h80AA_BB11, 0, 32'hFFFF_FFAA, 2'b00, 3, 1, 0, 0);
    do_load("lbu_k1",   3'b001, 32'h0000_1001, 32'h0,        32'h80AA_BB11, 0, 32'h0000_00BB, 2'b00, 3, 1, 0, 0);
    do_load("lhu_hi",   3'b011, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 32'h0000_8001, 2'b00, 3, 1, 0, 0);
    do_load("lh_hi",    3'b010, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 32'hFFFF_8001, 2'b00, 3, 1, 0, 0);
    do_load("lh_lo",    3'b010, 32'h0000_2000, 32'h0,        32'h8001_1234, 0, 32'h0000_1234, 2'b00, 3, 1, 0, 0);
    do_load("lwl_k1",   3'b110, 32'h0000_3001, 32'hAABB_CCDD, 32'h4433_2211, 0, 32'h2211_CCDD, 2'b00, 3, 1, 0, 0);
    do_load("lwr_k2",   3'b111, 32'h0000_3002, 32'hAABB_CCDD, 32'h4433_2211, 0, 32'hAABB_4433, 2'b00, 3, 1, 0, 0);
    do_load("lwl_k3",   3'b110, 32'h0000_3003, 32'hAABB_CCDD, 32'h4433_2211, 0, 32'h4433_2211, 2'b00, 3, 1, 0, 0);
    do_load("lwl_k0",   3'b110, 32'h0000_3000, 32'hAABB_CCDD, 32'h4433_2211, 0, 32'h11BB_CCDD, 2'b00, 3, 1, 0, 0);
    do_load("lwr_k0",   3'b111, 32'h0000_3000, 32'hAABB_CCDD, 32'h4433_2211, 0, 32'h4433_2211, 2'b00, 3, 1, 0, 0);
    do_load("lw_k0",    3'b101, 32'h0000_1000, 32'h0,        32'h1234_5678, 0, 32'h1234_5678, 2'b00, 3, 1, 0, 0);
`ifdef LOAD_ALIGN_MISALIGN_EN
    do_load("lw_mis",   3'b101, 32'h0000_1002, 32'h0,        32'h1234_5678, 0, 32'h0000_0000, 2'b01, 1, 0, 0, 0);
    do_load("lh_mis",   3'b010, 32'h0000_2003, 32'h0,        32'h8001_1234, 0, 32'h0000_0000, 2'b01, 1, 0, 0, 0);
`else
    do_load("lw_mis",   3'b101, 32'h0000_1002, 32'h0,        32'h1234_5678, 0, 32'h1234_5678, 2'b00, 3, 1, 0, 0);
    do_load("lh_mis",   3'b010, 32'h0000_2003, 32'h0,        32'h8001_1234, 0, 32'hFFFF_8001, 2'b00, 3, 1, 0, 0);
`endif
    do_load("illegal",  3'b100, 32'h0000_4000, 32'h0,        32'h1234_5678, 0, 32'h0000_0000, 2'b11, 1, 0, 0, 0);
    do_load("timeout",  3'b101, 32'h0000_5008, 32'h0,        32'h1234_5678, -1, 32'h0000_0000, 2'b10, 2 + TIMEOUT, 1, 3, 1);
    do_load("slow_mem", 3'b011, 32'h0000_2000, 32'h0,        32'hBEEF_8765, 4, 32'h0000_8765, 2'b00, 7, 1, 3, 0);

    // Reset asserted while the unit sits in WAIT aborts with no response.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'b101; req_addr = 32'h0000_5004; req_rt_old = '0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_wait_issue", 32'(mem_rd_en), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_wait");
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_wait_ready", 32'(req_ready), 32'd1);
    check("rst_wait_no_resp", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("rst_wait_still_no_resp", 32'(resp_valid), 32'd0);

    do_load("post_rst", 3'b000, 32'h0000_1003, 32'h0,        32'h80AA_BB11, 0, 32'hFFFF_FF80, 2'b00, 3, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
